// File: rtl/alu_mdu_pkg.sv
// Shared opcode values, FSM state type and op-class helper for the ALU/MDU.
package alu_mdu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per step.
// lo_out/hi_out present the post-step values so the caller can capture them on the last step.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic             op_div,
  input  logic             step_en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             last,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum, rem;
  logic [WIDTH-1:0] rdiff, step_hi, step_lo;
  logic             ge;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, product shifts in from the top.
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    // Divide: remainder < divisor always, so rem - divisor fits in WIDTH bits when ge.
    rem   = {hi_q, lo_q[WIDTH-1]};
    ge    = rem >= {1'b0, opb_q};
    rdiff = rem[WIDTH-1:0] - opb_q;
    if (div_q) begin
      step_hi = ge ? rdiff : rem[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign lo_out = step_lo;
  assign hi_out = step_hi;
  assign last   = step_en && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d  = '0;
      lo_d  = A;
      opb_d = B;
      div_d = op_div;
      cnt_d = '0;
    end else if (step_en) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative MULU/DIVU behind a start/busy/done handshake; all outputs registered.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             sign
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               mdu_load, mdu_step, mdu_last;
  logic [WIDTH-1:0]   mdu_lo, mdu_hi;

  assign shamt = A[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    unique case (ALUOp)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SLL:  alu_res = B << shamt;
      OP_OR:   alu_res = A | B;
      OP_AND:  alu_res = A & B;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR:  alu_res = A ^ B;
      OP_SRL:  alu_res = B >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(B) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .CLK     (CLK),
    .Reset   (Reset),
    .load    (mdu_load),
    .op_div  (ALUOp == OP_DIVU),
    .step_en (mdu_step),
    .A       (A),
    .B       (B),
    .last    (mdu_last),
    .lo_out  (mdu_lo),
    .hi_out  (mdu_hi)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    done_d   = 1'b0;
    mdu_load = 1'b0;
    mdu_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_multicycle(ALUOp)) begin
            mdu_load = 1'b1;
            state_d  = ST_RUN;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        mdu_step = 1'b1;
        if (mdu_last) begin
          result_d = mdu_lo;
          hi_d     = mdu_hi;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = (result_q == '0);
  assign sign   = result_q[WIDTH-1];

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboarded random + directed bench for alu_mdu at WIDTH=32 and WIDTH=8.
module tb_alu_mdu;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst = 1'b0, st = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0, b = '0, res, hi;
  logic        busy, done, zero, sign;

  logic        rst8 = 1'b0, st8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, res8, hi8;
  logic        busy8, done8, zero8, sign8;

  alu_mdu #(.WIDTH(32)) dut32 (
    .CLK(CLK), .Reset(rst), .start(st), .ALUOp(op), .A(a), .B(b),
    .busy(busy), .done(done), .result(res), .hi(hi), .zero(zero), .sign(sign));

  alu_mdu #(.WIDTH(8)) dut8 (
    .CLK(CLK), .Reset(rst8), .start(st8), .ALUOp(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .result(res8), .hi(hi8), .zero(zero8), .sign(sign8));

  typedef struct {
    longint unsigned res;
    longint unsigned hi;
    int unsigned     lat;
  } exp_t;

  exp_t            q32[$], q8[$];
  longint unsigned mhi32 = 0, mhi8 = 0;
  int              vectors = 0, miscompares = 0;
  int unsigned     bc32 = 0, bc8 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values, masked to w bits.
  function automatic exp_t model(input int unsigned o, input longint unsigned x,
                                 input longint unsigned y, input int unsigned w,
                                 input longint unsigned hprev);
    exp_t            e;
    longint unsigned mask, p;
    longint          sx, sy;
    int unsigned     sh;
    mask = (64'd1 << w) - 1;
    sh   = int'(x % w);
    sx   = ((x >> (w - 1)) & 1) != 0 ? longint'(x | ~mask) : longint'(x);
    sy   = ((y >> (w - 1)) & 1) != 0 ? longint'(y | ~mask) : longint'(y);
    e.hi  = hprev;
    e.lat = 0;
    case (o)
      0:  e.res = (x + y) & mask;
      1:  e.res = (x - y) & mask;
      2:  e.res = (y << sh) & mask;
      3:  e.res = x | y;
      4:  e.res = x & y;
      5:  e.res = (x < y) ? 1 : 0;
      6:  e.res = (sx < sy) ? 1 : 0;
      7:  e.res = x ^ y;
      8:  e.res = y >> sh;
      9:  e.res = longint'(sy >>> sh) & mask;
      10: begin
        p = x * y;
        e.res = p & mask;
        e.hi  = (p >> w) & mask;
        e.lat = w;
      end
      11: begin
        if (y == 0) begin
          e.res = mask;
          e.hi  = x;
        end else begin
          e.res = x / y;
          e.hi  = x % y;
        end
        e.lat = w;
      end
      default: e.res = 0;
    endcase
    return e;
  endfunction

  task automatic issue(input bit n8, input logic [3:0] o, input longint unsigned x,
                       input longint unsigned y);
    exp_t        e;
    int unsigned guard = 0;
    while ((n8 ? busy8 : busy) && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout actual=busy expected=idle within 200 cycles");
    end
    if (n8) begin
      e    = model(int'(o), x & 64'hFF, y & 64'hFF, 8, mhi8);
      mhi8 = e.hi;
      q8.push_back(e);
      st8 = 1'b1; op8 = o; a8 = 8'(x); b8 = 8'(y);
      @(negedge CLK);
      st8 = 1'b0;
    end else begin
      e     = model(int'(o), x & 64'hFFFFFFFF, y & 64'hFFFFFFFF, 32, mhi32);
      mhi32 = e.hi;
      q32.push_back(e);
      st = 1'b1; op = o; a = 32'(x); b = 32'(y);
      @(negedge CLK);
      st = 1'b0;
    end
  endtask

  task automatic do_reset(input bit n8);
    @(negedge CLK);
    #1;
    if (n8) begin
      rst8 = 1'b1; st8 = 1'b0; q8.delete(); mhi8 = 0;
    end else begin
      rst = 1'b1; st = 1'b0; q32.delete(); mhi32 = 0;
    end
    @(negedge CLK);
    #1;
    if (n8) begin
      check("rst8_busy", 64'(busy8), 64'd0);
      check("rst8_done", 64'(done8), 64'd0);
      check("rst8_result", 64'(res8), 64'd0);
      check("rst8_hi", 64'(hi8), 64'd0);
      check("rst8_zero", 64'(zero8), 64'd1);
      check("rst8_sign", 64'(sign8), 64'd0);
      rst8 = 1'b0;
    end else begin
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(res), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_sign", 64'(sign), 64'd0);
      rst = 1'b0;
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input longint unsigned r,
                         input longint unsigned h, input logic z, input logic s,
                         input int unsigned bc, input int unsigned w);
    check({tag, "_result"}, 64'(r), 64'(e.res));
    check({tag, "_hi"}, 64'(h), 64'(e.hi));
    check({tag, "_zero"}, 64'(z), (e.res == 0) ? 64'd1 : 64'd0);
    check({tag, "_sign"}, 64'(s), (e.res >> (w - 1)) & 64'd1);
    check({tag, "_busy_cycles"}, 64'(bc), 64'(e.lat));
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (rst) bc32 = 0;
    else begin
      if (busy) bc32++;
      if (done) begin
        if (q32.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL w32_unexpected_done actual=done expected=no_done at %0t", $time);
        end else begin
          e = q32.pop_front();
          compare("w32", e, res, hi, zero, sign, bc32, 32);
        end
        bc32 = 0;
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (rst8) bc8 = 0;
    else begin
      if (busy8) bc8++;
      if (done8) begin
        if (q8.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL w8_unexpected_done actual=done expected=no_done at %0t", $time);
        end else begin
          e = q8.pop_front();
          compare("w8", e, res8, hi8, zero8, sign8, bc8, 8);
        end
        bc8 = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned g;
    do_reset(1'b0);
    do_reset(1'b1);

    issue(1'b0, 4'b0000, 64'h7FFFFFFF, 64'd1);
    issue(1'b0, 4'b0001, 64'd5, 64'd5);
    issue(1'b0, 4'b0110, 64'hFFFFFFFF, 64'd1);
    issue(1'b0, 4'b0101, 64'hFFFFFFFF, 64'd1);
    issue(1'b0, 4'b1001, 64'd4, 64'hF0000000);
    issue(1'b0, 4'b1000, 64'd4, 64'hF0000000);
    issue(1'b0, 4'b0010, 64'd31, 64'd3);
    issue(1'b0, 4'b1101, 64'd7, 64'd9);

    issue(1'b0, 4'b1010, 64'hFFFFFFFF, 64'hFFFFFFFF);
    repeat (5) @(negedge CLK);
    st = 1'b1; op = 4'b0000; a = 32'd1; b = 32'd1;
    @(negedge CLK);
    st = 1'b0;

    issue(1'b0, 4'b1011, 64'd100, 64'd7);
    issue(1'b0, 4'b1011, 64'h1234, 64'd0);
    issue(1'b0, 4'b0000, 64'd2, 64'd3);

    // Abort a multiply mid-run; no done may follow.
    issue(1'b0, 4'b1010, 64'h12345678, 64'h9ABCDEF0);
    repeat (8) @(negedge CLK);
    do_reset(1'b0);
    repeat (40) @(negedge CLK);
    issue(1'b0, 4'b1010, 64'd3, 64'd7);

    for (int i = 0; i < 60; i++) begin
      longint unsigned x, y;
      x = 64'($urandom);
      y = (i % 4 == 0) ? 64'($urandom_range(0, 20)) : 64'($urandom);
      issue(1'b0, 4'($urandom_range(0, 15)), x, y);
    end

    issue(1'b1, 4'b1010, 64'hFF, 64'h02);
    issue(1'b1, 4'b0010, 64'd9, 64'd1);
    issue(1'b1, 4'b1011, 64'hC8, 64'd0);
    issue(1'b1, 4'b1001, 64'd3, 64'h80);
    for (int i = 0; i < 30; i++) begin
      issue(1'b1, 4'($urandom_range(0, 15)), 64'($urandom_range(0, 255)),
            64'($urandom_range(0, 255)));
    end

    g = 0;
    while ((q32.size() != 0 || q8.size() != 0) && g < 300) begin
      @(negedge CLK);
      g++;
    end
    check("pending_expectations", 64'(q32.size() + q8.size()), 64'd0);
    repeat (5) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the single-cycle CPU ALU. It keeps the eight existing operations and adds logical and arithmetic right shifts, plus an iterative unsigned multiply and an iterative unsigned divide. It sits in the EX stage and uses a start/busy/done handshake, so the control unit can stall the PC while a multi-cycle operation runs. All outputs are registered.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, at least 4.
SHAMT_W, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
CLK  input  1  clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
ALUOp  input  4  operation code (see Behaviour).
A  input  WIDTH  operand A; also the shift amount for shifts (low SHAMT_W bits).
B  input  WIDTH  operand B; the value that is shifted.
busy  output  1  multi-cycle operation in progress.
done  output  1  one-cycle pulse; result/hi valid from this cycle on.
result  output  WIDTH  main result; low half of product; quotient.
hi  output  WIDTH  high half of product, or remainder.
zero  output  1  result==0, derived from the registered result.
sign  output  1  result[WIDTH-1].

Behaviour:
- Opcodes:
  - 0000 ADD A+B (wraps); 0001 SUB A-B (wraps).
  - 0010 SLL B<<A[SHAMT_W-1:0].
  - 0011 OR; 0100 AND.
  - 0101 SLTU: unsigned A<B gives 1, else 0.
  - 0110 SLT: signed A<B gives 1, else 0.
  - 0111 XOR.
  - 1000 SRL: logical right shift of B by the shift amount. 1001 SRA: arithmetic right shift of B by the shift amount.
  - 1010 MULU: {hi,result} = A*B unsigned, 2*WIDTH bits.
  - 1011 DIVU: result = A/B, hi = A%B, unsigned.
  - 1100-1111 reserved: result = 0, hi unchanged, treated as single-cycle.
- FSM states: IDLE and RUN. busy = (state==RUN).
- IDLE, start=1, single-cycle op:
  - At that edge: result is registered, done=1 in the next cycle, state stays IDLE.
  - hi is unchanged. Latency is 1 edge.
- IDLE, start=1, MULU/DIVU:
  - At that edge: latch A, B and the op; iteration counter cnt=0; state becomes RUN.
  - done=0; result/hi hold their previous values.
- RUN: one iteration per edge.
  - MULU: shift-add of one multiplier bit.
  - DIVU: restoring step producing one quotient bit.
  - The edge with cnt==WIDTH-1 writes result and hi, pulses done, and returns to IDLE.
  - Total latency is WIDTH edges from the start edge; busy is high for exactly WIDTH cycles.
- start while busy=1: ignored. The input operands may change freely during RUN.
- start in the same cycle done is high: accepted (state is IDLE), so back-to-back operations are allowed.
- done is high for exactly one cycle per accepted start.
- DIVU with B=0: takes the full WIDTH cycles; result = all ones, hi = A. No trap.
- Reset:
  - result=0, hi=0, done=0, busy=0, state=IDLE, cnt=0.
  - Consequently zero=1 and sign=0.
  - Reset during RUN aborts the operation with no done pulse. Reset has priority over start.
- zero and sign always reflect the currently registered result, including while it is held during RUN.

Decomposition:
- Package alu_mdu_pkg:
  - ALUOp localparams (OP_ADD ... OP_DIVU).
  - FSM state encoding (ST_IDLE, ST_RUN).
  - op-class helper function is_multicycle(op).
- Sub-module mdu_iter:
  - Contains the shared 2*WIDTH accumulator/remainder register, the counter and the per-step add/subtract.
  - Interface: load, op_div, step_en, A, B, last, lo_out, hi_out.
- The single-cycle ops stay in alu_mdu as a combinational case, with a register on its output.

Test Plan:
- Reset, then start with ADD, A=0x7FFFFFFF, B=1: done one cycle later, result=0x80000000, sign=1, zero=0. Repeat with SUB, A=5, B=5: result=0, zero=1.
- SLT with A=0xFFFFFFFF, B=1 gives result=1; SLTU with the same operands gives 0. SRA with A=4, B=0xF0000000 gives 0xFF000000; SRL with A=4, B=0xF0000000 gives 0x0F000000.
- MULU with A=0xFFFFFFFF, B=0xFFFFFFFF: busy for 32 cycles, done on the 32nd edge, hi=0xFFFFFFFE, result=0x00000001. A start issued mid-run is ignored, with no extra done.
- DIVU with A=100, B=7 gives result=14, hi=2. DIVU with A=0x1234, B=0 gives result=0xFFFFFFFF, hi=0x1234. A second start issued in the done cycle (ADD 2+3) gives done one cycle later with result=5.
- Reset asserted at cycle 10 of a MULU: no done pulse follows, busy=0, result=0, hi=0, zero=1. The next start operates normally.
- WIDTH=8 instance: MULU with A=0xFF, B=0x02 gives hi=0x01, result=0xFE after exactly 8 cycles. SLL with A=9, B=1 uses shamt=A[2:0]=1, giving result=0x02.
